control_pipe_hazard: RTL and testbench
======================================

// Module: control_pipe_hazard
// PURPOSE
//  Pipelined successor to the combinational MIPS main decoder: decodes the ID-stage opcode and carries the
//  EX/M/WB control fields through internal ID/EX, EX/MEM and MEM/WB control registers.
//  Adds load-use stall detection, branch/jump flush with bubble insertion, a sticky illegal-opcode flag
//  and a bubble performance counter.
//  Sits between the IF/ID register and the datapath stage muxes of the 5-stage core.
// PARAMETERS
//  OPC_W    6   opcode width (encodings below assume 6)
//  REG_W    5   register-address width
//  ALUOP_W  3   ALUOp field width (>=3; codes zero-extended)
//  CNT_W    16  bubble counter width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  id_opcode      in   OPC_W    opcode of instruction in ID
//  id_valid       in   1        ID holds a real instruction
//  id_rs          in   REG_W    rs of ID instruction
//  id_rt          in   REG_W    rt of ID instruction
//  br_taken       in   1        branch in MEM resolved taken (mem_branch & zero, computed by datapath)
//  ex_reg_dst     out  1        from ID/EX ctrl reg
//  ex_alu_op      out  ALUOP_W  from ID/EX
//  ex_alu_src     out  1        from ID/EX
//  mem_branch     out  1        from EX/MEM
//  mem_read       out  1        from EX/MEM
//  mem_write      out  1        from EX/MEM
//  wb_reg_write   out  1        from MEM/WB
//  wb_mem_to_reg  out  1        from MEM/WB
//  jump           out  1        comb: valid J in ID, not stalled, no br_taken
//  stall          out  1        comb: load-use hazard
//  pc_write       out  1        comb: ~stall
//  ifid_write     out  1        comb: ~stall
//  ifid_flush     out  1        comb: br_taken | jump
//  illegal_op     out  1        sticky, registered
//  bubble_cnt     out  CNT_W    saturating count of inserted bubbles
// BEHAVIOUR
//  Decode (comb):
//   {RegWrite,MemToReg,Branch,MemRead,MemWrite,RegDst,ALUOp,ALUSrc}
//   R 000000=1,0,0,0,0,1,2,0 | LW 100011=1,1,0,1,0,0,0,1 | SW 101011=0,0,0,0,1,0,0,1
//   BEQ 000100=0,0,1,0,0,0,1,0 | ADDI 001000=1,0,0,0,0,0,0,1 | SLTI 001010=1,0,0,0,0,0,3,1
//   ANDI 001100=1,0,0,0,0,0,4,1 | ORI 001101=1,0,0,0,0,0,5,1 | J 000010=all 0, jump=1
//   Don't-care fields are driven 0; no X ever leaves the block. Any other opcode decodes all-zero.
//  Hazard:
//   stall = id_valid & idex_mem_read & idex_rt!=0 & (idex_rt==id_rs | idex_rt==id_rt) & ~br_taken.
//   idex_rt is id_rt captured into ID/EX each cycle.
//  Per rising edge, in priority order:
//   br_taken   -> ID/EX<=bubble, EX/MEM<=bubble, MEM/WB<=EX/MEM
//   stall      -> ID/EX<=bubble, EX/MEM<=ID/EX, MEM/WB<=EX/MEM
//   otherwise  -> ID/EX<=decode (bubble if ~id_valid or illegal), EX/MEM<=ID/EX, MEM/WB<=EX/MEM
//   A bubble is all-zero control.
//  Latency: opcode accepted at edge n -> ex_* valid after n, mem_* after n+1, wb_* after n+2.
//  jump and br_taken in the same cycle: br_taken wins and jump=0; ifid_flush=1 either way.
//  illegal_op sets on an edge with id_valid & unknown opcode & ~stall & ~br_taken; cleared only by reset.
//  bubble_cnt: +1 on each edge where stall|br_taken; holds at 2^CNT_W-1.
//  Reset (async, any time incl. mid-stall): all ctrl regs, idex_rt, illegal_op and bubble_cnt go to 0.
//   Every registered output reads 0 while rst_n=0.
// TESTING
//  R then LW then SW streamed -> ex_reg_dst=1,ex_alu_op=2 cycle1; mem_read=1 cycle3; mem_write=1 cycle4
//  LW rt=5 in EX, ADD rs=5 in ID -> stall=1,pc_write=0 one cycle; ex_* all 0 next; bubble_cnt=1
//  LW rt=0 in EX, ID rs=0 -> stall=0 (r0 exempt)
//  BEQ reaches MEM, br_taken=1 with stall condition true -> stall=0, ifid_flush=1, ex_*/mem_* 0 next cycle
//  J in ID -> jump=1, ifid_flush=1, ID/EX all 0; opcode 111111 valid -> illegal_op=1 until rst_n low
//  CNT_W=2, 5 stall cycles -> bubble_cnt saturates at 3; rst_n low mid-stall -> all outputs 0 immediately

Source files
------------

// File: rtl/control_pipe_hazard_if.sv
// Bundle between the ID/MEM datapath side and the pipelined control/hazard unit.
// master = datapath (drives ID fields and branch outcome), slave = control unit.
interface control_pipe_hazard_if #(
    parameter int OPC_W   = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    logic [OPC_W-1:0]   id_opcode;
    logic               id_valid;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               br_taken;
    logic               ex_reg_dst;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_alu_src;
    logic               mem_branch;
    logic               mem_read;
    logic               mem_write;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic               jump;
    logic               stall;
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               illegal_op;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output id_opcode, id_valid, id_rs, id_rt, br_taken,
        input  ex_reg_dst, ex_alu_op, ex_alu_src, mem_branch, mem_read, mem_write,
               wb_reg_write, wb_mem_to_reg, jump, stall, pc_write, ifid_write,
               ifid_flush, illegal_op, bubble_cnt
    );

    modport slave (
        input  id_opcode, id_valid, id_rs, id_rt, br_taken,
        output ex_reg_dst, ex_alu_op, ex_alu_src, mem_branch, mem_read, mem_write,
               wb_reg_write, wb_mem_to_reg, jump, stall, pc_write, ifid_write,
               ifid_flush, illegal_op, bubble_cnt
    );
endinterface

// File: rtl/control_pipe_hazard.sv
// Pipelined MIPS main decoder: ID decode carried through ID/EX, EX/MEM, MEM/WB control
// registers, with load-use stall, branch/jump flush, sticky illegal flag and bubble counter.
module control_pipe_hazard #(
    parameter int OPC_W   = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_pipe_hazard_if.slave bus
);

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
    } ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic mem_read;
        logic mem_write;
    } exmem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_t;

    localparam logic [OPC_W-1:0] OPC_J = 6'b000010;

    function automatic ctrl_t ctrl_row(input logic rw, input logic m2r, input logic br,
                                       input logic mr, input logic mw, input logic rd,
                                       input logic [2:0] aop, input logic as);
        ctrl_t c;
        c.reg_write  = rw;
        c.mem_to_reg = m2r;
        c.branch     = br;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.reg_dst    = rd;
        c.alu_op     = ALUOP_W'(aop);
        c.alu_src    = as;
        return c;
    endfunction

    // J and unknown opcodes fall to the all-zero row; legality is tracked separately.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opc);
        ctrl_t c;
        case (opc)
            6'b000000: c = ctrl_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
            6'b100011: c = ctrl_row(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
            6'b101011: c = ctrl_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
            6'b000100: c = ctrl_row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
            6'b001000: c = ctrl_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            6'b001010: c = ctrl_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
            6'b001100: c = ctrl_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
            6'b001101: c = ctrl_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        logic ok;
        case (opc)
            6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b001010, 6'b001100, 6'b001101,
            6'b000010: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    ctrl_t            idex_r;
    exmem_t           exmem_r;
    memwb_t           memwb_r;
    logic [REG_W-1:0] idex_rt_r;
    logic             illegal_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    ctrl_t            dec_ctrl_s;
    ctrl_t            idex_next_s;
    logic             legal_s;
    logic             hazard_s;
    logic             stall_s;
    logic             jump_s;

    // ID-stage decode, load-use detection and jump qualification.
    always_comb begin
        dec_ctrl_s = decode_ctrl(bus.id_opcode);
        legal_s    = opc_legal(bus.id_opcode);
        hazard_s   = bus.id_valid & idex_r.mem_read & (idex_rt_r != '0) &
                     ((idex_rt_r == bus.id_rs) | (idex_rt_r == bus.id_rt));
        // A taken branch squashes the ID instruction, so its hazard is moot.
        stall_s    = hazard_s & ~bus.br_taken;
        jump_s     = bus.id_valid & (bus.id_opcode == OPC_J) & ~stall_s & ~bus.br_taken;
        if (bus.id_valid & legal_s) begin
            idex_next_s = dec_ctrl_s;
        end else begin
            idex_next_s = '0;
        end
    end

    // Control pipeline registers; branch flush beats stall beats normal advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_r    <= '0;
            exmem_r   <= '0;
            memwb_r   <= '0;
            idex_rt_r <= '0;
        end else begin
            memwb_r   <= '{reg_write: exmem_r.reg_write, mem_to_reg: exmem_r.mem_to_reg};
            idex_rt_r <= bus.id_rt;
            if (bus.br_taken) begin
                idex_r  <= '0;
                exmem_r <= '0;
            end else begin
                exmem_r <= '{reg_write:  idex_r.reg_write,  mem_to_reg: idex_r.mem_to_reg,
                             branch:     idex_r.branch,     mem_read:   idex_r.mem_read,
                             mem_write:  idex_r.mem_write};
                idex_r  <= stall_s ? ctrl_t'('0) : idex_next_s;
            end
        end
    end

    // Sticky illegal-opcode flag; only an instruction that actually enters EX can set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (bus.id_valid & ~legal_s & ~stall_s & ~bus.br_taken) begin
            illegal_r <= 1'b1;
        end
    end

    // Saturating count of bubble-inserting edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= '0;
        end else if ((stall_s | bus.br_taken) && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.ex_reg_dst    = idex_r.reg_dst;
    assign bus.ex_alu_op     = idex_r.alu_op;
    assign bus.ex_alu_src    = idex_r.alu_src;
    assign bus.mem_branch    = exmem_r.branch;
    assign bus.mem_read      = exmem_r.mem_read;
    assign bus.mem_write     = exmem_r.mem_write;
    assign bus.wb_reg_write  = memwb_r.reg_write;
    assign bus.wb_mem_to_reg = memwb_r.mem_to_reg;
    assign bus.jump          = jump_s;
    assign bus.stall         = stall_s;
    assign bus.pc_write      = ~stall_s;
    assign bus.ifid_write    = ~stall_s;
    assign bus.ifid_flush    = bus.br_taken | jump_s;
    assign bus.illegal_op    = illegal_r;
    assign bus.bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_control_pipe_hazard.sv
// Randomized and directed bench for control_pipe_hazard against an instruction-level pipeline model.
module tb_control_pipe_hazard;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    control_pipe_hazard_if #(.OPC_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(16)) bus ();
    control_pipe_hazard_if #(.OPC_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(2))  bus2 ();

    control_pipe_hazard #(.OPC_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    control_pipe_hazard #(.OPC_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.id_opcode = bus.id_opcode;
    assign bus2.id_valid  = bus.id_valid;
    assign bus2.id_rs     = bus.id_rs;
    assign bus2.id_rt     = bus.id_rt;
    assign bus2.br_taken  = bus.br_taken;

    // Spec decode table; row = {RegWrite,MemToReg,Branch,MemRead,MemWrite,RegDst,ALUOp[2:0],ALUSrc}
    logic [5:0] tbl_opc [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                                6'b001010, 6'b001100, 6'b001101, 6'b000010};
    logic [9:0] tbl_row [9] = '{10'b1000010100, 10'b1101000001, 10'b0000100001,
                                10'b0010000010, 10'b1000000001, 10'b1000000111,
                                10'b1000001001, 10'b1000001011, 10'b0000000000};

    // Model: control word of the instruction occupying each stage (0 = bubble).
    logic [9:0] m_ex, m_mem, m_wb;
    logic [4:0] m_ex_rt;
    logic       m_ill;
    int         m_cnt;

    task automatic model_reset();
        m_ex = 10'd0; m_mem = 10'd0; m_wb = 10'd0; m_ex_rt = 5'd0; m_ill = 1'b0; m_cnt = 0;
    endtask

    task automatic ref_decode(input logic [5:0] opc, output logic [9:0] row,
                              output logic legal, output logic isj);
        row = 10'd0; legal = 1'b0; isj = (opc == OP_J);
        for (int i = 0; i < 9; i++) begin
            if (tbl_opc[i] == opc) begin
                row = tbl_row[i];
                legal = 1'b1;
            end
        end
    endtask

    // One clock: drive ID inputs, check comb outputs, advance the model, check registered outputs.
    task automatic drive_cycle(input logic [5:0] opc, input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic br);
        logic [9:0] row;
        logic legal, isj, st_e, jp_e;
        int   e16, e2;
        bus.id_opcode = opc; bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.br_taken = br;
        ref_decode(opc, row, legal, isj);
        st_e = v && m_ex[6] && (m_ex_rt != 5'd0) && (m_ex_rt == rs || m_ex_rt == rt) && !br;
        jp_e = v && isj && !st_e && !br;
        #1;
        total++;
        if (bus.stall !== st_e) begin
            bad++; $display("FAIL stall got=%0b exp=%0b t=%0t", bus.stall, st_e, $time);
        end
        total++;
        if ({bus.pc_write, bus.ifid_write} !== {!st_e, !st_e}) begin
            bad++; $display("FAIL pc_ifid_write got=%0b%0b exp=%0b t=%0t",
                            bus.pc_write, bus.ifid_write, !st_e, $time);
        end
        total++;
        if ({bus.jump, bus.ifid_flush} !== {jp_e, br || jp_e}) begin
            bad++; $display("FAIL jump_flush got=%0b%0b exp=%0b%0b t=%0t",
                            bus.jump, bus.ifid_flush, jp_e, br || jp_e, $time);
        end
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = br ? 10'd0 : m_ex;
        m_ex  = (br || st_e || !v || !legal) ? 10'd0 : row;
        m_ex_rt = rt;
        if (v && !legal && !st_e && !br) m_ill = 1'b1;
        if (st_e || br) m_cnt++;
        #1;
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src} !== m_ex[4:0]) begin
            bad++; $display("FAIL ex_ctrl got=%05b exp=%05b t=%0t",
                            {bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src}, m_ex[4:0], $time);
        end
        total++;
        if ({bus.mem_branch, bus.mem_read, bus.mem_write} !== m_mem[7:5]) begin
            bad++; $display("FAIL mem_ctrl got=%03b exp=%03b t=%0t",
                            {bus.mem_branch, bus.mem_read, bus.mem_write}, m_mem[7:5], $time);
        end
        total++;
        if ({bus.wb_reg_write, bus.wb_mem_to_reg} !== m_wb[9:8]) begin
            bad++; $display("FAIL wb_ctrl got=%02b exp=%02b t=%0t",
                            {bus.wb_reg_write, bus.wb_mem_to_reg}, m_wb[9:8], $time);
        end
        total++;
        if (bus.illegal_op !== m_ill) begin
            bad++; $display("FAIL illegal_op got=%0b exp=%0b t=%0t", bus.illegal_op, m_ill, $time);
        end
        e16 = (m_cnt > 65535) ? 65535 : m_cnt;
        e2  = (m_cnt > 3) ? 3 : m_cnt;
        total++;
        if (bus.bubble_cnt !== 16'(e16)) begin
            bad++; $display("FAIL bubble_cnt got=%0d exp=%0d t=%0t", bus.bubble_cnt, e16, $time);
        end
        total++;
        if (bus2.bubble_cnt !== 2'(e2)) begin
            bad++; $display("FAIL bubble_cnt_w2 got=%0d exp=%0d t=%0t", bus2.bubble_cnt, e2, $time);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.id_opcode = OP_LW; bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd1;
        bus.br_taken = 1'b0;
        #1;
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src, bus.mem_branch, bus.mem_read,
             bus.mem_write, bus.wb_reg_write, bus.wb_mem_to_reg, bus.illegal_op} !== 13'd0) begin
            bad++; $display("FAIL reset_regs got=nonzero exp=0");
        end
        total++;
        if ({bus.bubble_cnt, bus.stall} !== 17'd0) begin
            bad++; $display("FAIL reset_cnt_stall got=%0d/%0b exp=0/0", bus.bubble_cnt, bus.stall);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        drive_cycle(OP_R, 1'b1, 5'd1, 5'd2, 1'b0);
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op} !== 4'b1010) begin
            bad++; $display("FAIL stream_r got=%0b/%0d exp=1/2", bus.ex_reg_dst, bus.ex_alu_op);
        end
        drive_cycle(OP_LW, 1'b1, 5'd1, 5'd3, 1'b0);
        drive_cycle(OP_SW, 1'b1, 5'd6, 5'd7, 1'b0);
        total++;
        if (bus.mem_read !== 1'b1) begin
            bad++; $display("FAIL stream_lw_mem got=%0b exp=1", bus.mem_read);
        end
        drive_cycle(OP_R, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if ({bus.mem_write, bus.wb_mem_to_reg} !== 2'b11) begin
            bad++; $display("FAIL stream_sw_mem got=%0b%0b exp=11", bus.mem_write, bus.wb_mem_to_reg);
        end
    endtask

    task automatic test_load_use();
        int cnt_before;
        drive_cycle(OP_LW, 1'b1, 5'd0, 5'd5, 1'b0);
        bus.id_opcode = OP_R; bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd6;
        #1;
        total++;
        if ({bus.stall, bus.pc_write} !== 2'b10) begin
            bad++; $display("FAIL load_use got=%0b%0b exp=10", bus.stall, bus.pc_write);
        end
        cnt_before = m_cnt;
        drive_cycle(OP_R, 1'b1, 5'd5, 5'd6, 1'b0);
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src} !== 5'd0 ||
            bus.bubble_cnt !== 16'(cnt_before + 1)) begin
            bad++; $display("FAIL load_use_bubble got=%0d cnt=%0d exp=0 cnt=%0d",
                            bus.ex_alu_op, bus.bubble_cnt, cnt_before + 1);
        end
        drive_cycle(OP_R, 1'b1, 5'd5, 5'd6, 1'b0);
    endtask

    task automatic test_r0();
        drive_cycle(OP_LW, 1'b1, 5'd1, 5'd0, 1'b0);
        bus.id_opcode = OP_R; bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("FAIL r0_exempt got=%0b exp=0", bus.stall);
        end
        drive_cycle(OP_R, 1'b1, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_branch();
        drive_cycle(OP_BEQ, 1'b1, 5'd1, 5'd2, 1'b0);
        drive_cycle(OP_LW, 1'b1, 5'd1, 5'd3, 1'b0);
        bus.id_opcode = OP_R; bus.id_valid = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
        bus.br_taken = 1'b1;
        #1;
        total++;
        if ({bus.mem_branch, bus.stall, bus.ifid_flush} !== 3'b101) begin
            bad++; $display("FAIL branch_flush got=%0b%0b%0b exp=101",
                            bus.mem_branch, bus.stall, bus.ifid_flush);
        end
        drive_cycle(OP_R, 1'b1, 5'd3, 5'd4, 1'b1);
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src,
             bus.mem_branch, bus.mem_read, bus.mem_write} !== 8'd0) begin
            bad++; $display("FAIL branch_bubble got=%0b exp=0",
                            {bus.ex_alu_op, bus.mem_read, bus.mem_branch});
        end
    endtask

    task automatic test_jump();
        drive_cycle(OP_R, 1'b1, 5'd1, 5'd2, 1'b0);
        bus.id_opcode = OP_J; bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.br_taken = 1'b0;
        #1;
        total++;
        if ({bus.jump, bus.ifid_flush} !== 2'b11) begin
            bad++; $display("FAIL jump got=%0b%0b exp=11", bus.jump, bus.ifid_flush);
        end
        drive_cycle(OP_J, 1'b1, 5'd0, 5'd0, 1'b0);
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src} !== 5'd0) begin
            bad++; $display("FAIL jump_idex got=%0d exp=0", bus.ex_alu_op);
        end
    endtask

    task automatic test_illegal();
        drive_cycle(OP_BAD, 1'b1, 5'd0, 5'd0, 1'b0);
        drive_cycle(OP_R, 1'b1, 5'd1, 5'd2, 1'b0);
        drive_cycle(OP_SW, 1'b1, 5'd1, 5'd2, 1'b0);
        total++;
        if (bus.illegal_op !== 1'b1) begin
            bad++; $display("FAIL illegal_sticky got=%0b exp=1", bus.illegal_op);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            drive_cycle(OP_LW, 1'b1, 5'd0, 5'd2, 1'b0);
            drive_cycle(OP_R, 1'b1, 5'd2, 5'd1, 1'b0);
            drive_cycle(OP_R, 1'b1, 5'd2, 5'd1, 1'b0);
        end
        total++;
        if (bus2.bubble_cnt !== 2'd3) begin
            bad++; $display("FAIL saturate got=%0d exp=3", bus2.bubble_cnt);
        end
    endtask

    task automatic test_random(input int n);
        logic [5:0] opc;
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = $urandom_range(0, 9);
            opc = (idx == 9) ? 6'($urandom) : tbl_opc[idx];
            drive_cycle(opc, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), m_mem[7] && ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_cycle(OP_LW, 1'b1, 5'd0, 5'd4, 1'b0);
        bus.id_opcode = OP_R; bus.id_valid = 1'b1; bus.id_rs = 5'd4; bus.id_rt = 5'd1;
        bus.br_taken = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("FAIL mid_stall_pre got=%0b exp=1", bus.stall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ex_reg_dst, bus.ex_alu_op, bus.ex_alu_src, bus.mem_branch, bus.mem_read,
             bus.mem_write, bus.wb_reg_write, bus.wb_mem_to_reg, bus.illegal_op,
             bus.stall} !== 14'd0) begin
            bad++; $display("FAIL mid_stall_reset got=nonzero exp=0 t=%0t", $time);
        end
        total++;
        if ({bus.bubble_cnt, bus2.bubble_cnt} !== 18'd0) begin
            bad++; $display("FAIL mid_stall_cnt got=%0d/%0d exp=0/0", bus.bubble_cnt, bus2.bubble_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_load_use();
        test_r0();
        test_branch();
        test_jump();
        test_illegal();
        test_saturate();
        test_random(500);
        test_reset_mid_stall();
        test_random(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
